boruhatti_besleyici: RTL and testbench

BORUHATTI_BESLEYICI -- requirements
Module: boruhatti_besleyici

---
 rtl/boruhatti_besleyici_pkg.sv | 18 +
 rtl/boruhatti_besleyici_if.sv | 35 +++
 rtl/boruhatti_besleyici.sv | 128 ++++++++++++
 tb/tb_boruhatti_besleyici.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/boruhatti_besleyici_pkg.sv
// Shared constants, FSM state type and sum-width helper for the
// serial-to-parallel operand feeder of the pipelined adder.
package boruhatti_pkg;

  localparam int OPERAND_ADET = 8;
  localparam int INDEX_W      = 3;

  typedef enum logic {
    BOS,
    TOPLA
  } durum_t;

  // Eight N-bit unsigned operands sum without overflow in N+3 bits.
  function automatic int toplam_w(input int n);
    return n + 3;
  endfunction

endpackage

// File: rtl/boruhatti_besleyici_if.sv
// Operand stream and parallel batch bus of boruhatti_besleyici.
// master = stream producer / batch consumer, slave = the feeder block.
interface boruhatti_besleyici_if #(
  parameter int N = 8
);
  import boruhatti_pkg::*;

  logic [N-1:0]             veri_giris;
  logic                     veri_etkin;
  logic                     veri_hazir;
  logic                     temizle;
  logic [N-1:0]             sayi1;
  logic [N-1:0]             sayi2;
  logic [N-1:0]             sayi3;
  logic [N-1:0]             sayi4;
  logic [N-1:0]             sayi5;
  logic [N-1:0]             sayi6;
  logic [N-1:0]             sayi7;
  logic [N-1:0]             sayi8;
  logic                     giris_etkin;
  logic [toplam_w(N)-1:0]   beklenen_toplam;

  modport master (
    output veri_giris, veri_etkin, temizle,
    input  veri_hazir, sayi1, sayi2, sayi3, sayi4, sayi5, sayi6, sayi7, sayi8,
    input  giris_etkin, beklenen_toplam
  );

  modport slave (
    input  veri_giris, veri_etkin, temizle,
    output veri_hazir, sayi1, sayi2, sayi3, sayi4, sayi5, sayi6, sayi7, sayi8,
    output giris_etkin, beklenen_toplam
  );

endinterface

// File: rtl/boruhatti_besleyici.sv
// boruhatti_besleyici: collects a serial operand stream into batches of
// eight, issues them in parallel with a one-cycle giris_etkin pulse and
// the exact reference sum for checking the downstream adder.
// Optional macro BORUHATTI_BESLEYICI_SAYAC_EN adds a 16-bit batch counter
// output paket_sayisi.
module boruhatti_besleyici
  import boruhatti_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  boruhatti_besleyici_if.slave  bus
`ifdef BORUHATTI_BESLEYICI_SAYAC_EN
  ,
  output logic [15:0]           paket_sayisi
`endif
);

  localparam int SW = toplam_w(N);

  durum_t              durum_q, durum_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [SW-1:0]       acc_q, acc_d;
  logic [SW-1:0]       acc_toplam;
  logic [SW-1:0]       din_ext;
  logic                kabul;
  logic                ver;

  logic [N-1:0]        buf_p0  [OPERAND_ADET];
  logic [N-1:0]        sayi_p1 [OPERAND_ADET];
  logic [SW-1:0]       toplam_p1;
  logic                vld_p1;

  assign bus.veri_hazir = rst_n & ~bus.temizle;
  assign kabul          = bus.veri_etkin & bus.veri_hazir;
  assign din_ext        = {{(SW-N){1'b0}}, bus.veri_giris};
  // Slot 1 (state BOS) restarts the running sum from the incoming operand.
  assign acc_toplam     = (durum_q == BOS) ? din_ext : acc_q + din_ext;

  // Next-state logic: fill index, running sum and batch-complete strobe.
  always_comb begin
    durum_d = durum_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ver     = 1'b0;
    if (bus.temizle) begin
      durum_d = BOS;
      idx_d   = '0;
      acc_d   = '0;
    end else if (kabul) begin
      if (idx_q == INDEX_W'(OPERAND_ADET - 1)) begin
        ver     = 1'b1;
        durum_d = BOS;
        idx_d   = '0;
        acc_d   = '0;
      end else begin
        durum_d = TOPLA;
        idx_d   = idx_q + INDEX_W'(1);
        acc_d   = acc_toplam;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q <= BOS;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      durum_q <= durum_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  // Stage p0: collection buffer, written in arrival order; only slots
  // 1..7 are read back, the 8th operand goes straight to the outputs.
  always_ff @(posedge clk) begin
    if (kabul) begin
      buf_p0[idx_q] <= bus.veri_giris;
    end
  end

  // Stage p1: issued batch, held until the next batch completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OPERAND_ADET; i++) begin
        sayi_p1[i] <= '0;
      end
      toplam_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= ver;
      if (ver) begin
        for (int i = 0; i < OPERAND_ADET - 1; i++) begin
          sayi_p1[i] <= buf_p0[i];
        end
        sayi_p1[OPERAND_ADET-1] <= bus.veri_giris;
        toplam_p1               <= acc_toplam;
      end
    end
  end

  assign bus.sayi1           = sayi_p1[0];
  assign bus.sayi2           = sayi_p1[1];
  assign bus.sayi3           = sayi_p1[2];
  assign bus.sayi4           = sayi_p1[3];
  assign bus.sayi5           = sayi_p1[4];
  assign bus.sayi6           = sayi_p1[5];
  assign bus.sayi7           = sayi_p1[6];
  assign bus.sayi8           = sayi_p1[7];
  assign bus.giris_etkin     = vld_p1;
  assign bus.beklenen_toplam = toplam_p1;

`ifdef BORUHATTI_BESLEYICI_SAYAC_EN
  // Batch counter, advancing together with each giris_etkin pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paket_sayisi <= '0;
    end else if (ver) begin
      paket_sayisi <= paket_sayisi + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_boruhatti_besleyici.sv
// Self-checking bench for boruhatti_besleyici: directed scenarios plus a
// randomized stream, checked every cycle against a queue-based batch model.
module tb_boruhatti_besleyici;
  import boruhatti_pkg::*;

  localparam int N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  boruhatti_besleyici_if #(.N(N)) bus ();

`ifdef BORUHATTI_BESLEYICI_SAYAC_EN
  logic [15:0] paket_sayisi;
`endif

  boruhatti_besleyici #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BORUHATTI_BESLEYICI_SAYAC_EN
    ,
    .paket_sayisi (paket_sayisi)
`endif
  );

  int n_test = 0;
  int n_fail = 0;

  // Behavioural model: operands of the current batch, and the last issued batch.
  int q[$];
  int exp_sayi[8];
  int exp_toplam;
  bit exp_etkin;
  int exp_paket;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 8; i++) exp_sayi[i] = 0;
    exp_toplam = 0;
    exp_etkin  = 1'b0;
    exp_paket  = 0;
  endtask

  // Drive one cycle of inputs, then advance the model by that edge.
  task automatic step(input bit en, input int d, input bit clr);
    bus.veri_etkin = en;
    bus.veri_giris = d[7:0];
    bus.temizle    = clr;
    @(posedge clk);
    exp_etkin = 1'b0;
    if (rst_n) begin
      if (clr) begin
        q.delete();
      end else if (en) begin
        q.push_back(d & 255);
        if (q.size() == 8) begin
          int s;
          s = 0;
          for (int i = 0; i < 8; i++) begin
            exp_sayi[i] = q[i];
            s += q[i];
          end
          exp_toplam = s;
          exp_etkin  = 1'b1;
          exp_paket  = (exp_paket + 1) % 65536;
          q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic do_reset(input int cyc);
    rst_n          = 1'b0;
    bus.veri_etkin = 1'b0;
    bus.veri_giris = '0;
    bus.temizle    = 1'b0;
    model_clear();
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // Compare process: every cycle, on the falling edge.
  initial begin
    logic [7:0] act[8];
    forever begin
      @(negedge clk);
      if (chk_on) begin
        act = '{bus.sayi1, bus.sayi2, bus.sayi3, bus.sayi4,
                bus.sayi5, bus.sayi6, bus.sayi7, bus.sayi8};
        chk("giris_etkin", {31'b0, bus.giris_etkin}, {31'b0, exp_etkin});
        chk("beklenen_toplam", {21'b0, bus.beklenen_toplam}, exp_toplam);
        for (int i = 0; i < 8; i++)
          chk($sformatf("sayi%0d", i + 1), {24'b0, act[i]}, exp_sayi[i]);
        chk("veri_hazir", {31'b0, bus.veri_hazir},
            (rst_n && !bus.temizle) ? 32'd1 : 32'd0);
`ifdef BORUHATTI_BESLEYICI_SAYAC_EN
        chk("paket_sayisi", {16'b0, paket_sayisi}, exp_paket);
`endif
      end
    end
  end

  initial begin
    bus.veri_etkin = 1'b0;
    bus.veri_giris = '0;
    bus.temizle    = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_hazir", {31'b0, bus.veri_hazir}, 0);
    chk("rst_toplam", {21'b0, bus.beklenen_toplam}, 0);
    chk("rst_etkin", {31'b0, bus.giris_etkin}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Stream 1..8 back-to-back.
    for (int v = 1; v <= 8; v++) begin
      step(1'b1, v, 1'b0);
      chk("p1_etkin_step", {31'b0, bus.giris_etkin}, (v == 8) ? 32'd1 : 32'd0);
    end
    chk("p1_model_toplam", exp_toplam, 36);
    chk("p1_toplam", {21'b0, bus.beklenen_toplam}, 36);
    chk("p1_sayi1", {24'b0, bus.sayi1}, 1);
    chk("p1_sayi8", {24'b0, bus.sayi8}, 8);
    step(1'b0, 0, 1'b0);
    chk("p1_etkin_tek", {31'b0, bus.giris_etkin}, 0);

    // Eight 0xFF operands: full 11-bit sum.
    for (int i = 0; i < 8; i++) step(1'b1, 255, 1'b0);
    chk("p2_toplam", {21'b0, bus.beklenen_toplam}, 32'h7F8);
    step(1'b0, 0, 1'b0);

    // 10..25 back-to-back: two pulses 8 cycles apart.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 10 + i, 1'b0);
      chk("p3_etkin", {31'b0, bus.giris_etkin}, (i == 7 || i == 15) ? 32'd1 : 32'd0);
      if (i >= 7 && i < 15) chk("p3_sayi1_tut", {24'b0, bus.sayi1}, 10);
    end
    chk("p3_model_toplam", exp_toplam, 172);
    chk("p3_sayi1", {24'b0, bus.sayi1}, 18);
    chk("p3_toplam", {21'b0, bus.beklenen_toplam}, 172);
    step(1'b0, 0, 1'b0);

    // Three operands, temizle with a valid operand, then eight 5s.
    for (int i = 0; i < 3; i++) step(1'b1, 100 + i, 1'b0);
    bus.veri_etkin = 1'b1;
    bus.veri_giris = 8'd77;
    bus.temizle    = 1'b1;
    #1;
    chk("p4_hazir_temizle", {31'b0, bus.veri_hazir}, 0);
    step(1'b1, 77, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5, 1'b0);
      chk("p4_etkin", {31'b0, bus.giris_etkin}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("p4_toplam", {21'b0, bus.beklenen_toplam}, 40);
    step(1'b0, 0, 1'b0);

    // Five operands, reset mid-batch, then a fresh batch.
    for (int i = 0; i < 5; i++) step(1'b1, 200 + i, 1'b0);
    do_reset(2);
    chk("p5_rst_toplam", {21'b0, bus.beklenen_toplam}, 0);
    chk("p5_rst_sayi1", {24'b0, bus.sayi1}, 0);
    chk("p5_rst_etkin", {31'b0, bus.giris_etkin}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 30 + i, 1'b0);
    chk("p5_sayi1", {24'b0, bus.sayi1}, 30);
    chk("p5_toplam", {21'b0, bus.beklenen_toplam}, 268);
    step(1'b0, 0, 1'b0);

    // Randomized stream with gaps and occasional temizle.
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 10) < 7, int'($urandom % 256), ($urandom % 25) == 0);
    end
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

`ifdef BORUHATTI_BESLEYICI_SAYAC_EN
    force dut.paket_sayisi = 16'hFFFF;
    exp_paket = 65535;
    @(negedge clk);
    release dut.paket_sayisi;
    #1;
    for (int i = 0; i < 8; i++) step(1'b1, i, 1'b0);
    chk("p7_paket_sar", {16'b0, paket_sayisi}, 0);
    step(1'b0, 0, 1'b0);
`endif

    @(negedge clk);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
